// File: rtl/countdown_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | countdown_arbiter: round-robin arbiter sharing one loadable down-counter   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module countdown_arbiter #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] count_in,
    output logic [N-1:0]   grant,
    output logic           busy,
    output logic [W-1:0]   count,
    output logic [N-1:0]   done
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         r_state;
    logic [N-1:0]   r_grant;
    logic [N-1:0]   r_done;
    logic [W-1:0]   r_count;
    logic [PW-1:0]  r_ptr;
    logic [PW-1:0]  r_sel;

    logic [PW-1:0]  w_sel;
    logic           w_any;
    logic [W-1:0]   w_load;
    logic [N-1:0]   w_onehot;
    logic [PW-1:0]  w_ptr_next;

    // Scan offsets high-to-low so the nearest set bit at or after r_ptr wins.
    always_comb begin
        int idx;
        w_sel = '0;
        w_any = 1'b0;
        idx   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(r_ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (req[idx]) begin
                w_sel = PW'(idx);
                w_any = 1'b1;
            end
        end
    end

    always_comb begin
        w_load   = count_in[int'(w_sel)*W +: W];
        w_onehot = {{(N-1){1'b0}}, 1'b1} << w_sel;
        w_ptr_next = (r_sel == PW'(N - 1)) ? '0 : r_sel + PW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_done  <= '0;
            r_count <= '0;
            r_ptr   <= '0;
            r_sel   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= '0;
                    if (w_any) begin
                        r_grant <= w_onehot;
                        r_sel   <= w_sel;
                        r_count <= w_load;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (!req[r_sel]) begin
                        // Abandoned: release without a done pulse, count keeps its value.
                        r_grant <= '0;
                        r_ptr   <= w_ptr_next;
                        r_state <= S_IDLE;
                    end else if (r_count == '0) begin
                        r_done  <= r_grant;
                        r_state <= S_DONE;
                    end else begin
                        r_count <= r_count - W'(1);
                    end
                end
                S_DONE: begin
                    r_done  <= '0;
                    r_grant <= '0;
                    r_ptr   <= w_ptr_next;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= '0;
                    r_grant <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign grant = r_grant;
    assign busy  = |r_grant;
    assign count = r_count;
    assign done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_countdown_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_countdown_arbiter: table-driven, scoreboarded bench for the arbiter     |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_countdown_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] count_in;
    logic [N-1:0]   grant;
    logic           busy;
    logic [W-1:0]   count;
    logic [N-1:0]   done;

    countdown_arbiter #(.N(N), .W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .count_in (count_in),
        .grant    (grant),
        .busy     (busy),
        .count    (count),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] grant;
        logic         busy;
        logic [W-1:0] count;
        logic [N-1:0] done;
    } exp_t;

    typedef struct {
        logic           rst;
        logic [N-1:0]   req;
        logic [N*W-1:0] cin;
        exp_t           exp;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input logic r, input logic [3:0] rq,
                                input int l0, input int l1, input int l2, input int l3,
                                input logic [3:0] g, input logic b, input int c,
                                input logic [3:0] d);
        vec_t v;
        v.rst       = r;
        v.req       = rq;
        v.cin       = {8'(l3), 8'(l2), 8'(l1), 8'(l0)};
        v.exp.grant = g;
        v.exp.busy  = b;
        v.exp.count = 8'(c);
        v.exp.done  = d;
        return v;
    endfunction

    task automatic check_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL %s scoreboard empty", tag);
            return;
        end
        e = sb.pop_front();
        checks += 4;
        if (grant !== e.grant) begin
            errors++;
            $display("FAIL %s grant got %b want %b", tag, grant, e.grant);
        end
        if (busy !== e.busy) begin
            errors++;
            $display("FAIL %s busy got %b want %b", tag, busy, e.busy);
        end
        if (count !== e.count) begin
            errors++;
            $display("FAIL %s count got %0d want %0d", tag, count, e.count);
        end
        if (done !== e.done) begin
            errors++;
            $display("FAIL %s done got %b want %b", tag, done, e.done);
        end
    endtask

    task automatic step(input vec_t v, input string tag);
        rst      = v.rst;
        req      = v.req;
        count_in = v.cin;
        sb.push_back(v.exp);
        @(posedge clk);
        #1;
        check_out(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst      = 1'b0;
        req      = '0;
        count_in = '0;

        // reset held with all requests pending
        vecs.push_back(mk(0, 4'hF, 1,1,1,1, 4'h0,0,0,4'h0));
        vecs.push_back(mk(0, 4'hF, 1,1,1,1, 4'h0,0,0,4'h0));
        // round robin, every load = 1
        vecs.push_back(mk(1, 4'hF, 1,1,1,1, 4'h1,1,1,4'h0));
        vecs.push_back(mk(1, 4'hF, 1,1,1,1, 4'h1,1,0,4'h0));
        vecs.push_back(mk(1, 4'hF, 1,1,1,1, 4'h1,1,0,4'h1));
        vecs.push_back(mk(1, 4'hF, 1,1,1,1, 4'h0,0,0,4'h0));
        vecs.push_back(mk(1, 4'hF, 1,1,1,1, 4'h2,1,1,4'h0));
        vecs.push_back(mk(1, 4'hF, 1,1,1,1, 4'h2,1,0,4'h0));
        vecs.push_back(mk(1, 4'hF, 1,1,1,1, 4'h2,1,0,4'h2));
        vecs.push_back(mk(1, 4'hF, 1,1,1,1, 4'h0,0,0,4'h0));
        vecs.push_back(mk(1, 4'hF, 1,1,1,1, 4'h4,1,1,4'h0));
        vecs.push_back(mk(1, 4'hF, 1,1,1,1, 4'h4,1,0,4'h0));
        vecs.push_back(mk(1, 4'hF, 1,1,1,1, 4'h4,1,0,4'h4));
        vecs.push_back(mk(1, 4'hF, 1,1,1,1, 4'h0,0,0,4'h0));
        vecs.push_back(mk(1, 4'hF, 1,1,1,1, 4'h8,1,1,4'h0));
        vecs.push_back(mk(1, 4'hF, 1,1,1,1, 4'h8,1,0,4'h0));
        vecs.push_back(mk(1, 4'hF, 1,1,1,1, 4'h8,1,0,4'h8));
        vecs.push_back(mk(1, 4'hF, 1,1,1,1, 4'h0,0,0,4'h0));
        vecs.push_back(mk(1, 4'hF, 1,1,1,1, 4'h1,1,1,4'h0));
        vecs.push_back(mk(1, 4'hF, 1,1,1,1, 4'h1,1,0,4'h0));
        vecs.push_back(mk(1, 4'hF, 1,1,1,1, 4'h1,1,0,4'h1));
        vecs.push_back(mk(1, 4'h0, 1,1,1,1, 4'h0,0,0,4'h0));
        // single request on requester 2, L=3
        vecs.push_back(mk(1, 4'h4, 1,1,3,1, 4'h4,1,3,4'h0));
        vecs.push_back(mk(1, 4'h4, 1,1,3,1, 4'h4,1,2,4'h0));
        vecs.push_back(mk(1, 4'h4, 1,1,3,1, 4'h4,1,1,4'h0));
        vecs.push_back(mk(1, 4'h4, 1,1,3,1, 4'h4,1,0,4'h0));
        vecs.push_back(mk(1, 4'h4, 1,1,3,1, 4'h4,1,0,4'h4));
        vecs.push_back(mk(1, 4'h0, 1,1,3,1, 4'h0,0,0,4'h0));
        // zero load on requester 1
        vecs.push_back(mk(1, 4'h2, 1,0,1,1, 4'h2,1,0,4'h0));
        vecs.push_back(mk(1, 4'h2, 1,0,1,1, 4'h2,1,0,4'h2));
        vecs.push_back(mk(1, 4'h0, 1,0,1,1, 4'h0,0,0,4'h0));
        // abort requester 2 (L=10) with requester 3 pending (L=2)
        vecs.push_back(mk(1, 4'hC, 1,1,10,2, 4'h4,1,10,4'h0));
        vecs.push_back(mk(1, 4'hC, 1,1,10,2, 4'h4,1,9,4'h0));
        vecs.push_back(mk(1, 4'hC, 1,1,10,2, 4'h4,1,8,4'h0));
        vecs.push_back(mk(1, 4'hC, 1,1,10,2, 4'h4,1,7,4'h0));
        vecs.push_back(mk(1, 4'hC, 1,1,10,2, 4'h4,1,6,4'h0));
        vecs.push_back(mk(1, 4'h8, 1,1,10,2, 4'h0,0,6,4'h0));
        vecs.push_back(mk(1, 4'h8, 1,1,10,2, 4'h8,1,2,4'h0));
        vecs.push_back(mk(1, 4'h8, 1,1,10,2, 4'h8,1,1,4'h0));
        vecs.push_back(mk(1, 4'h8, 1,1,10,2, 4'h8,1,0,4'h0));
        vecs.push_back(mk(1, 4'h8, 1,1,10,2, 4'h8,1,0,4'h8));
        vecs.push_back(mk(1, 4'h0, 1,1,10,2, 4'h0,0,0,4'h0));
        // zero load on requester 1 again, moves pointer to 2
        vecs.push_back(mk(1, 4'h2, 5,0,1,1, 4'h2,1,0,4'h0));
        vecs.push_back(mk(1, 4'h2, 5,0,1,1, 4'h2,1,0,4'h2));
        vecs.push_back(mk(1, 4'h0, 5,0,1,1, 4'h0,0,0,4'h0));

        foreach (vecs[i]) begin
            step(vecs[i], $sformatf("vec%0d", i));
        end

        // asynchronous reset in the middle of a run on requester 0 (L=5)
        step(mk(1, 4'h1, 5,0,1,1, 4'h1,1,5,4'h0), "arst_e0");
        step(mk(1, 4'h1, 5,0,1,1, 4'h1,1,4,4'h0), "arst_e1");
        step(mk(1, 4'h1, 5,0,1,1, 4'h1,1,3,4'h0), "arst_e2");
        #2;
        rst = 1'b0;
        sb.push_back('{grant: 4'h0, busy: 1'b0, count: 8'd0, done: 4'h0});
        #1;
        check_out("arst_async");
        step(mk(0, 4'h7, 5,0,1,1, 4'h0,0,0,4'h0), "arst_hold");
        // pointer must be back at 0: requester 0 wins over 1 and 2
        step(mk(1, 4'h7, 5,0,1,1, 4'h1,1,5,4'h0), "arst_regrant");
        step(mk(1, 4'h7, 5,0,1,1, 4'h1,1,4,4'h0), "arst_run");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/countdown_arbiter.md
# countdown_arbiter

Shares one programmable down-counter among `N` requesters under round-robin arbitration. The winning requester's load value is counted down to zero, then a one-cycle `done` pulse is returned to that requester only. It sits beside the Moore/Mealy countdown blocks as the scheduler that lets several clients time-share a single countdown datapath. All outputs are registered or decoded from registered state, so they are Moore-style.

## Interface
Parameters:
- `N`, 4: number of requesters; must be ≥ 2.
- `W`, 8: counter width in bits.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `req`  in  N  level request, one bit per requester; held until `done` or abandoned.
- `count_in`  in  N*W  packed load values; requester i at bits [i*W +: W]; sampled only at grant.
- `grant`  out  N  one-hot owner of the counter; all-zero when idle.
- `busy`  out  1  high while in LOAD/RUN/DONE (i.e. `grant` != 0).
- `count`  out  W  current counter value.
- `done`  out  N  one-hot, one-cycle completion pulse to the granted requester.

## Operation
- Reset (`rst`=0, immediate and asynchronous):
  - FSM returns to IDLE.
  - `grant`=0, `busy`=0, `done`=0, `count`=0.
  - Round-robin pointer `ptr`=0.
- FSM states and transitions:
  - IDLE:
    - If `req` != 0, select the first set bit searching i = ptr, ptr+1, … mod N.
    - Register `grant`=onehot(sel) and `count`=`count_in[sel]`, then go to RUN.
    - Otherwise stay in IDLE.
  - RUN (checks in this priority order):
    1. If `req[sel]`=0: abort. Go to IDLE, clear `grant`, set `ptr`=sel+1 mod N, no `done`.
    2. Else if `count`=0: go to DONE.
    3. Else `count` <= `count`-1.
  - DONE:
    - `done[sel]`=1 for exactly this one cycle.
    - `grant` is still held.
    - Next edge: go to IDLE, clear `grant`, set `ptr`=sel+1 mod N.
- Arithmetic: `count` is unsigned `W`-bit. It never decrements below 0, so it never wraps. A load of 0 is legal.
- `count` holds its last value (0, or the value at abort) while in IDLE, until the next grant.
- Requests other than `sel` are ignored while `busy`. There is no preemption.
- A `req` change during DONE has no effect; the pulse still completes.
- `count_in` changes after the grant edge have no effect.
- `ptr` updates only on completion or abort, so a requester that holds `req` is granted within N arbitration rounds (starvation-free).

## Timing
- Let edge 0 be the IDLE edge where `req` is seen.
- After edge 0: `grant`, `busy` high; `count`=L.
- After edge k (1 ≤ k ≤ L): `count`=L-k.
- After edge L+1: DONE state, `done[sel]`=1.
- After edge L+2: back in IDLE, `grant`=0, `done`=0.
- Latency: `done` rises L+1 cycles after `grant` rises. Total occupancy is L+2 cycles.
- Back-to-back: the earliest next grant is edge L+3. There is one mandatory IDLE cycle between owners.
- Abort: if `req[sel]` falls before edge j while in RUN, `grant` clears after edge j.
- Reset mid-operation: outputs clear immediately on `rst` falling, with no `done` pulse. Operation resumes at the first rising edge after `rst` rises, with `ptr`=0.

## Test plan
- Reset values: hold `rst`=0 with `req`=4'b1111 → `grant`=0, `busy`=0, `done`=0, `count`=0. After release, the first grant is 4'b0001.
- Single request, L=3, `req`=4'b0100:
  - `grant`=4'b0100 after edge 0.
  - `count` reads 3,2,1,0 after edges 0–3.
  - `done`=4'b0100 after edge 4 only.
  - `grant`=0 after edge 5.
- Zero load, L=0 on requester 1: `done`=4'b0010 after edge 1; `busy` lasts exactly 2 cycles.
- Round robin: `req`=4'b1111 held, all loads=1:
  - Grants in order 0001 → 0010 → 0100 → 1000 → 0001.
  - Each `done` pulse reaches only the matching requester.
  - Each grant occupies 3 cycles, with one IDLE cycle between grants.
- Abort: requester 2 with L=10 drops `req` after 4 RUN cycles:
  - `grant` clears on the next edge; no `done` pulse.
  - If requester 3 is pending, it is granted next.
- Async reset mid-RUN: requester 0 with L=5, assert `rst`=0 between edges 2 and 3:
  - All outputs go to 0 without waiting for an edge.
  - After release, re-arbitration starts at requester 0.
